// File: rtl/rr_arbiter.sv
// rr_arbiter: N-channel fixed-priority / round-robin arbiter with registered one-hot grant and hold limit
//   i_clk         clock, all state updates on rising edge
//   i_res_n       asynchronous active-low reset
//   i_req         level-sensitive request per channel
//   i_mode        0 = fixed priority (lowest index), 1 = round-robin after last winner
//   o_grant       registered one-hot grant or all zero
//   o_grant_valid registered, equals |o_grant
//   o_grant_id    index of granted channel, 0 when idle
module rr_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic           i_clk,
  input  logic           i_res_n,
  input  logic [N-1:0]   i_req,
  input  logic           i_mode,
  output logic [N-1:0]   o_grant,
  output logic           o_grant_valid,
  output logic [IDW-1:0] o_grant_id
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam bit HOLD_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  localparam logic [N-1:0] ONE = N'(1);
  state_t r_state, w_state_nxt;
  logic [N-1:0] r_grant, w_grant_nxt, w_cand;
  logic [IDW-1:0] r_id, r_last, w_id_nxt, w_last_nxt, w_win;
  logic [7:0] r_hold, w_hold_nxt;
  logic w_own_req, w_others, w_arb, w_keep;
  // Scans candidates from the highest search position down so the earliest
  // position in search order is the last one written.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] c, input logic m, input logic [IDW-1:0] last);
    logic [IDW-1:0] r;
    int idx;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = m ? (int'(last) + 1 + k) % N : k;
      if (c[idx]) r = IDW'(idx);
    end
    return r;
  endfunction
  always_comb begin
    w_own_req = i_req[r_id];
    w_others = |(i_req & ~r_grant);
    // >= rather than == so an owner that already outlived the limit alone
    // is preempted as soon as someone else starts waiting.
    w_arb = (r_state == IDLE || !w_own_req) ? |i_req : (HOLD_EN && r_hold >= HOLD_LAST && w_others);
    w_keep = r_state == BUSY && w_own_req && !w_arb;
    w_cand = (r_state == BUSY && w_own_req) ? (i_req & ~r_grant) : i_req;
    w_win = pick(w_cand, i_mode, r_last);
    w_state_nxt = (w_arb || w_keep) ? BUSY : IDLE;
    w_grant_nxt = w_arb ? (ONE << w_win) : (w_keep ? r_grant : '0);
    w_id_nxt = w_arb ? w_win : (w_keep ? r_id : '0);
    w_last_nxt = w_arb ? w_win : r_last;
    w_hold_nxt = w_arb ? 8'd0 : ((w_keep && r_hold != 8'hff) ? r_hold + 8'd1 : r_hold);
  end
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_id <= '0;
      r_last <= IDW'(N - 1);
      r_hold <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_id <= w_id_nxt;
      r_last <= w_last_nxt;
      r_hold <= w_hold_nxt;
    end
  end
  assign o_grant = r_grant;
  assign o_grant_valid = (r_state == BUSY);
  assign o_grant_id = r_id;
endmodule
